mem_access_unit: RTL and testbench

//   Load/store sequencer between the multi-cycle controller's memory stage and the wishbone host/master

---
 rtl/mem_access_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the memory stage and the wishbone command and
//   response channel. It takes one RISC-V load or store and issues ADDR, READ
//   and WRITE commands. Sub-word stores use read-modify-write. Loads are
//   sign-extended or zero-extended. Illegal funct3 and misaligned requests
//   fail at once. A read response that never arrives ends in a timeout.
//
//   Ports
//     clk_i, reset_i        clock (rising edge), async active-low reset
//     req_valid_i/ready_o   request handshake; ready only while idle
//     req_we_i              1 = store, 0 = load
//     req_funct3_i          RISC-V funct3
//     req_addr_i            byte address
//     req_wdata_i           right-aligned store data
//     done_o                one-cycle completion pulse (also on error)
//     rdata_o               extended load data, held until the next done
//     err_o, err_code_o     failure flag; 01 misaligned, 10 illegal, 11 timeout
//     cmd_stb_o, cmd_word_o command {op, payload}; op 00 ADDR, 01 WRITE, 10 READ
//     cmd_busy_i            master stalls the command
//     rsp_stb_i, rsp_word_i read response, data in the low XLEN bits
//
//   state     | meaning
//   S_IDLE    | waiting for a request
//   S_ADDR    | ADDR command presented
//   S_RD_CMD  | READ command presented
//   S_RD_WAIT | waiting for the read response, timeout running
//   S_WR_CMD  | WRITE command presented
//   S_DONE    | done pulse cycle
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic            cmd_stb_o,
  output logic [XLEN+1:0] cmd_word_o,
  input  logic            cmd_busy_i,
  input  logic            rsp_stb_i,
  input  logic [XLEN+1:0] rsp_word_i
);

  localparam int NB   = XLEN / 8;
  localparam int OFFB = $clog2(NB);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] OP_ADDR    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] E_MISALIGN = 2'b01;
  localparam logic [1:0] E_ILLEGAL  = 2'b10;
  localparam logic [1:0] E_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD_CMD, S_RD_WAIT, S_WR_CMD, S_DONE
  } state_e;

  state_e            state_q;
  logic              done_q, err_q, cmd_stb_q, we_q;
  logic [1:0]        err_code_q;
  logic [XLEN-1:0]   rdata_q, wdata_q;
  logic [XLEN+1:0]   cmd_word_q;
  logic [2:0]        f3_q;
  logic [OFFB-1:0]   off_q;
  logic [TW-1:0]     cnt_q;

  logic              req_illegal, req_misalign;
  logic [3:0]        size_mask;
  logic [XLEN-1:0]   rsp_data, rsp_shift, load_ext_d, wdata_shift, merge_d;
  logic              full_width, to_hit;
  logic              unused_rsp_op;

  assign unused_rsp_op = ^rsp_word_i[XLEN+1:XLEN];

  // Request decode on the raw inputs; only sampled while idle.
  always_comb begin
    req_illegal = 1'b1;
    if (req_we_i) begin
      case (req_funct3_i)
        3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
        3'b011:                 req_illegal = (XLEN != 64);
        default:                req_illegal = 1'b1;
      endcase
    end else begin
      case (req_funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        3'b011, 3'b110:                         req_illegal = (XLEN != 64);
        default:                                req_illegal = 1'b1;
      endcase
    end
    size_mask    = (4'd1 << req_funct3_i[1:0]) - 4'd1;
    req_misalign = |(req_addr_i[2:0] & size_mask[2:0]);
  end

  assign rsp_data   = rsp_word_i[XLEN-1:0];
  assign rsp_shift  = rsp_data >> {off_q, 3'b000};
  assign full_width = (int'(f3_q[1:0]) == OFFB);
  assign to_hit     = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    case (f3_q)
      3'b000:  load_ext_d = XLEN'($signed(rsp_shift[7:0]));
      3'b001:  load_ext_d = XLEN'($signed(rsp_shift[15:0]));
      3'b010:  load_ext_d = XLEN'($signed(rsp_shift[31:0]));
      3'b100:  load_ext_d = XLEN'(rsp_shift[7:0]);
      3'b101:  load_ext_d = XLEN'(rsp_shift[15:0]);
      3'b110:  load_ext_d = XLEN'(rsp_shift[31:0]);
      default: load_ext_d = rsp_shift;
    endcase
  end

  // Replace only the byte lanes covered by the store; keep the rest of the read word.
  always_comb begin
    wdata_shift = wdata_q << {off_q, 3'b000};
    merge_d     = rsp_data;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(off_q)) && (b < int'(off_q) + (1 << f3_q[1:0])))
        merge_d[b*8 +: 8] = wdata_shift[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      rdata_q    <= '0;
      cmd_stb_q  <= 1'b0;
      cmd_word_q <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            off_q   <= req_addr_i[OFFB-1:0];
            wdata_q <= req_wdata_i;
            if (req_illegal || req_misalign) begin
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= req_illegal ? E_ILLEGAL : E_MISALIGN;
              state_q    <= S_DONE;
            end else begin
              cmd_stb_q  <= 1'b1;
              cmd_word_q <= {OP_ADDR, req_addr_i & ~XLEN'(NB - 1)};
              state_q    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (!cmd_busy_i) begin
            if (we_q && full_width) begin
              cmd_word_q <= {OP_WRITE, wdata_q};
              state_q    <= S_WR_CMD;
            end else begin
              cmd_word_q <= {OP_READ, {XLEN{1'b0}}};
              state_q    <= S_RD_CMD;
            end
          end
        end
        S_RD_CMD: begin
          if (!cmd_busy_i) begin
            cmd_stb_q  <= 1'b0;
            cmd_word_q <= '0;
            cnt_q      <= '0;
            state_q    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // A response arriving on the terminal count still wins.
          if (rsp_stb_i) begin
            if (we_q) begin
              cmd_stb_q  <= 1'b1;
              cmd_word_q <= {OP_WRITE, merge_d};
              state_q    <= S_WR_CMD;
            end else begin
              rdata_q    <= load_ext_d;
              err_q      <= 1'b0;
              err_code_q <= '0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end
          end else if (to_hit) begin
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            err_code_q <= E_TIMEOUT;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WR_CMD: begin
          if (!cmd_busy_i) begin
            cmd_stb_q  <= 1'b0;
            cmd_word_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign cmd_stb_o   = cmd_stb_q;
  assign cmd_word_o  = cmd_word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  typedef struct packed {
    logic        err;
    logic [1:0]  code;
    logic        chk_rd;
    logic [63:0] rdata;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid, rsp_stb;
  logic        req_we, cmd_busy;
  logic [2:0]  req_f3;
  logic [63:0] req_addr, req_wdata;
  logic [65:0] rsp_word;

  logic        rdy32, done32, err32, stb32;
  logic [1:0]  code32;
  logic [31:0] rdata32;
  logic [33:0] cw32;
  logic        rdy64, done64, err64, stb64;
  logic [1:0]  code64;
  logic [63:0] rdata64;
  logic [65:0] cw64;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt[2]   = '{0, 0};
  int done_cnt[2] = '{0, 0};
  int rd_cyc[2]   = '{0, 0};
  int done_cyc[2] = '{0, 0};

  logic [33:0] q_cmd32[$];
  logic [65:0] q_cmd64[$];
  done_t       q_done32[$];
  done_t       q_done64[$];
  done_t       d32, d64;

  mem_access_unit #(.XLEN(32), .TIMEOUT(4)) u32 (
    .clk_i(clk), .reset_i(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(rdy32),
    .req_we_i(req_we), .req_funct3_i(req_f3), .req_addr_i(req_addr[31:0]),
    .req_wdata_i(req_wdata[31:0]), .done_o(done32), .rdata_o(rdata32), .err_o(err32),
    .err_code_o(code32), .cmd_stb_o(stb32), .cmd_word_o(cw32), .cmd_busy_i(cmd_busy),
    .rsp_stb_i(rsp_stb[0]), .rsp_word_i(rsp_word[33:0])
  );

  mem_access_unit #(.XLEN(64), .TIMEOUT(0)) u64 (
    .clk_i(clk), .reset_i(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(rdy64),
    .req_we_i(req_we), .req_funct3_i(req_f3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .done_o(done64), .rdata_o(rdata64), .err_o(err64),
    .err_code_o(code64), .cmd_stb_o(stb64), .cmd_word_o(cw64), .cmd_busy_i(1'b0),
    .rsp_stb_i(rsp_stb[1]), .rsp_word_i(rsp_word)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [65:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, required nothing", name, act);
  endtask

  // Monitor for the 32-bit unit: commands, busy hold, done responses.
  logic        pstb32 = 1'b0;
  logic        pbusy32 = 1'b0;
  logic [33:0] pcw32 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pstb32 = 1'b0;
    end else begin
      if (pstb32 && pbusy32) begin
        check("cmd32_hold_stb", 66'(stb32), 66'(1'b1));
        check("cmd32_hold_word", 66'(cw32), 66'(pcw32));
      end
      if (stb32 && !cmd_busy) begin
        if (cw32[33:32] == 2'b10) begin
          rd_cnt[0]++;
          rd_cyc[0] = cyc;
        end
        if (q_cmd32.size() == 0) flag("cmd32_unexpected", 66'(cw32));
        else check("cmd32_word", 66'(cw32), 66'(q_cmd32.pop_front()));
      end
      if (done32) begin
        done_cnt[0]++;
        done_cyc[0] = cyc;
        if (q_done32.size() == 0) flag("done32_unexpected", 66'(err32));
        else begin
          d32 = q_done32.pop_front();
          check("done32_err", 66'(err32), 66'(d32.err));
          if (d32.err) check("done32_code", 66'(code32), 66'(d32.code));
          if (d32.chk_rd) check("done32_rdata", 66'(rdata32), 66'(d32.rdata));
        end
      end
      pstb32  = stb32;
      pbusy32 = cmd_busy;
      pcw32   = cw32;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stb64) begin
        if (cw64[65:64] == 2'b10) begin
          rd_cnt[1]++;
          rd_cyc[1] = cyc;
        end
        if (q_cmd64.size() == 0) flag("cmd64_unexpected", cw64);
        else check("cmd64_word", cw64, q_cmd64.pop_front());
      end
      if (done64) begin
        done_cnt[1]++;
        done_cyc[1] = cyc;
        if (q_done64.size() == 0) flag("done64_unexpected", 66'(err64));
        else begin
          d64 = q_done64.pop_front();
          check("done64_err", 66'(err64), 66'(d64.err));
          if (d64.err) check("done64_code", 66'(code64), 66'(d64.code));
          if (d64.chk_rd) check("done64_rdata", 66'(rdata64), 66'(d64.rdata));
        end
      end
    end
  end

  task automatic push_cmd(input int w, input logic [1:0] op, input logic [63:0] pay);
    if (w == 0) q_cmd32.push_back({op, pay[31:0]});
    else q_cmd64.push_back({op, pay});
  endtask

  task automatic push_done(input int w, input logic e, input logic [1:0] c,
                           input logic chk, input logic [63:0] rd);
    done_t t;
    t.err = e; t.code = c; t.chk_rd = chk; t.rdata = rd;
    if (w == 0) q_done32.push_back(t);
    else q_done64.push_back(t);
  endtask

  task automatic issue(input int w, input logic we, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd);
    @(posedge clk); #1;
    req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    req_valid[w] = 1'b1;
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
  endtask

  task automatic respond(input int w, input int base, input logic [63:0] data, input int extra);
    int i = 0;
    while (rd_cnt[w] == base && i < 50) begin
      @(negedge clk); #1;
      i++;
    end
    if (rd_cnt[w] == base) flag("read_cmd_wait_expired", 66'(w));
    else begin
      repeat (1 + extra) @(posedge clk);
      #1;
      rsp_word = {2'b00, data};
      rsp_stb[w] = 1'b1;
      @(posedge clk); #1;
      rsp_stb[w] = 1'b0;
    end
  endtask

  task automatic wait_done(input int w, input int base);
    int i = 0;
    while (done_cnt[w] == base && i < 50) begin
      @(negedge clk); #1;
      i++;
    end
    if (done_cnt[w] == base) flag("done_wait_expired", 66'(w));
    @(posedge clk);
  endtask

  task automatic load(input int w, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] al, input logic [63:0] rsp,
                      input logic [63:0] exp_rd, input int extra);
    int rb = rd_cnt[w];
    int db = done_cnt[w];
    push_cmd(w, 2'b00, al);
    push_cmd(w, 2'b10, 64'h0);
    push_done(w, 1'b0, 2'b00, 1'b1, exp_rd);
    issue(w, 1'b0, f3, a, 64'h0);
    respond(w, rb, rsp, extra);
    wait_done(w, db);
  endtask

  task automatic store(input int w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] al, input logic [63:0] wd, input logic rmw,
                       input logic [63:0] rsp, input logic [63:0] wpay);
    int rb = rd_cnt[w];
    int db = done_cnt[w];
    push_cmd(w, 2'b00, al);
    if (rmw) push_cmd(w, 2'b10, 64'h0);
    push_cmd(w, 2'b01, wpay);
    push_done(w, 1'b0, 2'b00, 1'b0, 64'h0);
    issue(w, 1'b1, f3, a, wd);
    if (rmw) respond(w, rb, rsp, 0);
    wait_done(w, db);
  endtask

  task automatic bad(input int w, input logic we, input logic [2:0] f3,
                     input logic [63:0] a, input logic [1:0] code);
    int db = done_cnt[w];
    push_done(w, 1'b1, code, 1'b0, 64'h0);
    issue(w, we, f3, a, 64'h55);
    @(negedge clk); #1;
    check("err_done_next_cycle", 66'(w == 0 ? done32 : done64), 66'(1'b1));
    wait_done(w, db);
  endtask

  initial begin
    int rb;
    int db;
    int i;
    rst_n = 1'b0;
    req_valid = '0; rsp_stb = '0; req_we = 1'b0; cmd_busy = 1'b0;
    req_f3 = '0; req_addr = '0; req_wdata = '0; rsp_word = '0;
    #2;
    check("rst_ready", 66'(rdy32), 66'(1'b1));
    check("rst_done", 66'(done32), 66'(1'b0));
    check("rst_err", 66'(err32), 66'(1'b0));
    check("rst_code", 66'(code32), 66'(2'b00));
    check("rst_cmd_stb", 66'(stb32), 66'(1'b0));
    check("rst_cmd_word", 66'(cw32), 66'(0));
    check("rst_rdata", 66'(rdata32), 66'(0));
    check("rst_ready64", 66'(rdy64), 66'(1'b1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Loads and extension on the 32-bit unit.
    load(0, 3'b010, 64'h100, 64'h100, 64'hDEADBEEF, 64'hDEADBEEF, 0);
    load(0, 3'b000, 64'h103, 64'h100, 64'h80FFFF7F, 64'hFFFFFF80, 0);
    load(0, 3'b100, 64'h103, 64'h100, 64'h80FFFF7F, 64'h00000080, 0);
    load(0, 3'b001, 64'h102, 64'h100, 64'h80FFFF7F, 64'hFFFF80FF, 0);
    load(0, 3'b101, 64'h102, 64'h100, 64'h80FFFF7F, 64'h000080FF, 0);
    load(0, 3'b000, 64'h105, 64'h104, 64'h0000_7F00, 64'h0000007F, 0);

    // Stores: sub-word read-modify-write and full word.
    store(0, 3'b000, 64'h102, 64'h100, 64'hAB, 1'b1, 64'h11223344, 64'h11AB3344);
    store(0, 3'b001, 64'h102, 64'h100, 64'hBEEF, 1'b1, 64'h11223344, 64'hBEEF3344);
    store(0, 3'b010, 64'h104, 64'h104, 64'h12345678, 1'b0, 64'h0, 64'h12345678);

    // Error paths; illegal beats misaligned.
    bad(0, 1'b0, 3'b010, 64'h102, 2'b01);
    bad(0, 1'b0, 3'b001, 64'h101, 2'b01);
    bad(0, 1'b1, 3'b100, 64'h100, 2'b10);
    bad(0, 1'b0, 3'b011, 64'h101, 2'b10);
    bad(0, 1'b0, 3'b111, 64'h100, 2'b10);

    // Command stall for three cycles with a stray request in flight.
    rb = rd_cnt[0]; db = done_cnt[0];
    push_cmd(0, 2'b00, 64'h200);
    push_cmd(0, 2'b10, 64'h0);
    push_done(0, 1'b0, 2'b00, 1'b1, 64'h13579BDF);
    @(posedge clk); #1 cmd_busy = 1'b1;
    issue(0, 1'b0, 3'b010, 64'h200, 64'h0);
    req_valid[0] = 1'b1; req_addr = 64'h300;
    @(negedge clk); #1;
    check("busy_req_ready", 66'(rdy32), 66'(1'b0));
    repeat (3) @(posedge clk);
    #1;
    cmd_busy = 1'b0; req_valid[0] = 1'b0;
    respond(0, rb, 64'h13579BDF, 0);
    wait_done(0, db);

    // Timeout after four wait cycles, then a response on the terminal count.
    db = done_cnt[0];
    push_cmd(0, 2'b00, 64'h180);
    push_cmd(0, 2'b10, 64'h0);
    push_done(0, 1'b1, 2'b11, 1'b0, 64'h0);
    issue(0, 1'b0, 3'b010, 64'h180, 64'h0);
    wait_done(0, db);
    check("timeout_latency", 66'(done_cyc[0] - rd_cyc[0]), 66'(5));
    load(0, 3'b010, 64'h180, 64'h180, 64'h0BADCAFE, 64'h0BADCAFE, 3);

    // Stray response while idle must do nothing.
    @(posedge clk); #1 rsp_stb[0] = 1'b1; rsp_word = 66'h0FFFF;
    @(posedge clk); #1 rsp_stb[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_rsp_ready", 66'(rdy32), 66'(1'b1));

    // Reset while waiting for the read response.
    rb = rd_cnt[0];
    push_cmd(0, 2'b00, 64'h1C0);
    push_cmd(0, 2'b10, 64'h0);
    issue(0, 1'b0, 3'b010, 64'h1C0, 64'h0);
    i = 0;
    while (rd_cnt[0] == rb && i < 50) begin
      @(negedge clk); #1;
      i++;
    end
    if (rd_cnt[0] == rb) flag("reset_read_wait_expired", 66'(0));
    @(posedge clk);
    @(negedge clk); #2;
    check("rd_wait_ready", 66'(rdy32), 66'(1'b0));
    rst_n = 1'b0;
    #1;
    check("abort_cmd_stb", 66'(stb32), 66'(1'b0));
    check("abort_done", 66'(done32), 66'(1'b0));
    check("abort_ready", 66'(rdy32), 66'(1'b1));
    @(posedge clk); #1 rst_n = 1'b1;
    load(0, 3'b010, 64'h100, 64'h100, 64'hCAFEF00D, 64'hCAFEF00D, 0);

    // 64-bit unit.
    load(1, 3'b011, 64'h108, 64'h108, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0);
    load(1, 3'b110, 64'h10C, 64'h108, 64'h8000000000000000, 64'h0000000080000000, 0);
    load(1, 3'b010, 64'h10C, 64'h108, 64'h8000000000000000, 64'hFFFFFFFF80000000, 0);
    store(1, 3'b011, 64'h110, 64'h110, 64'h1122334455667788, 1'b0, 64'h0, 64'h1122334455667788);
    store(1, 3'b010, 64'h114, 64'h110, 64'hDEADBEEF, 1'b1, 64'hAAAAAAAABBBBBBBB, 64'hDEADBEEFBBBBBBBB);
    bad(1, 1'b0, 3'b011, 64'h10C, 2'b01);

    repeat (3) @(posedge clk);
    check("cmd32_left", 66'(q_cmd32.size()), 66'(0));
    check("done32_left", 66'(q_done32.size()), 66'(0));
    check("cmd64_left", 66'(q_cmd64.size()), 66'(0));
    check("done64_left", 66'(q_done64.size()), 66'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
